// File: rtl/fifo_burst_drain.sv
// rtl/fifo_burst_drain.sv - burst-draining consumer for the byte FIFO
// Pops FIFO entries in threshold/timeout-triggered bursts into a 2-entry valid/ready output buffer.
module fifo_burst_drain #(
  parameter int MAX_DATA  = 16,
  parameter int BURST_LEN = 4,
  parameter int THRESHOLD = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic       ren,
  input  logic [7:0] rdata,
  input  logic       empty,
  input  logic [4:0] count,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       busy,
  output logic [7:0] burst_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [4:0]    BLEN = 5'((BURST_LEN > MAX_DATA) ? MAX_DATA : BURST_LEN);
  localparam logic [4:0]    THR  = 5'(THRESHOLD);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BURST, WAIT_LAST} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [4:0]    beats_left;
  logic [4:0]    len;
  logic [1:0]    buf_occ;
  logic          rd_ptr, wr_ptr;
  logic [7:0]    buf_data [2];
  logic          buf_last [2];
  logic          start, pop;

  assign start   = (count >= THR) || (count != 5'd0 && timer == TMAX);
  assign len     = (count < BLEN) ? count : BLEN;
  assign m_valid = buf_occ != 2'd0;
  assign m_data  = buf_data[rd_ptr];
  assign m_last  = m_valid && buf_last[rd_ptr];
  assign pop     = m_valid && m_ready;
  assign busy    = state != IDLE;

  // ren looks only at registered state and empty, so backpressure never reaches the FIFO read path
  always_comb begin
    state_nxt = state;
    ren       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = BURST;
      end
      BURST: begin
        ren = !rst && !empty && beats_left != 5'd0 && buf_occ != 2'd2;
        if (ren && beats_left == 5'd1) state_nxt = WAIT_LAST;
      end
      WAIT_LAST: begin
        if (pop && m_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      beats_left <= 5'd0;
      buf_occ    <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      burst_cnt  <= 8'd0;
    end else begin
      state <= state_nxt;
      // a start always leaves IDLE, so this branch only runs for 0 < count < THRESHOLD
      if (state == IDLE && !start && count != 5'd0) begin
        if (timer != TMAX) timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end
      if (state == IDLE && start) beats_left <= len;
      else if (ren)               beats_left <= beats_left - 5'd1;
      buf_occ <= buf_occ + {1'b0, ren} - {1'b0, pop};
      if (ren) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      if (state == WAIT_LAST && pop && m_last) burst_cnt <= burst_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (ren) begin
      buf_data[wr_ptr] <= rdata;
      buf_last[wr_ptr] <= (beats_left == 5'd1);
    end
  end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb/tb_fifo_burst_drain.sv - directed self-checking bench for fifo_burst_drain
`timescale 1ns/1ps
module tb_fifo_burst_drain;

  logic       clk = 1'b0;
  logic       rst, fifo_clr;
  logic       ren, empty, m_valid, m_ready, m_last, busy;
  logic [7:0] rdata, m_data, burst_cnt;
  logic [4:0] count;
  logic       wr_en;
  logic [7:0] wr_data;

  logic       w_en, w_ren, w_m_valid, w_m_last, w_busy;
  logic [7:0] w_m_data, w_burst_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fifo_burst_drain u_dut (
    .clk(clk), .rst(rst), .ren(ren), .rdata(rdata), .empty(empty), .count(count),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .burst_cnt(burst_cnt)
  );

  fifo_burst_drain #(.BURST_LEN(1), .THRESHOLD(1)) u_wrap (
    .clk(clk), .rst(rst), .ren(w_ren), .rdata(8'h5A), .empty(!w_en), .count({4'd0, w_en}),
    .m_valid(w_m_valid), .m_ready(1'b1), .m_data(w_m_data), .m_last(w_m_last),
    .busy(w_busy), .burst_cnt(w_burst_cnt)
  );

  // upstream FIFO model
  logic [7:0] fmem [16];
  logic [3:0] frp, fwp;
  logic [4:0] fcnt;
  assign rdata = fmem[frp];
  assign count = fcnt;
  assign empty = fcnt == 5'd0;

  always @(posedge clk) begin
    if (fifo_clr) begin
      frp <= 4'd0; fwp <= 4'd0; fcnt <= 5'd0;
    end else begin
      if (ren) frp <= frp + 4'd1;
      if (wr_en) begin
        fmem[fwp] <= wr_data;
        fwp <= fwp + 4'd1;
      end
      fcnt <= fcnt + {4'd0, wr_en} - {4'd0, ren};
    end
  end

  // observers: accepted beats {last,data}, ren pulses, ren-while-empty, wrap-instance bursts
  logic [8:0] log_q [$];
  int ren_pulses = 0;
  int ren_empty  = 0;
  int w_accepts  = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (ren) ren_pulses <= ren_pulses + 1;
      if (ren && empty) ren_empty <= ren_empty + 1;
      if (m_valid && m_ready) log_q.push_back({m_last, m_data});
      if (w_m_valid && w_m_last) w_accepts <= w_accepts + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_bc(input logic [7:0] exp, input int budget, input string tag);
    int g = 0;
    while (burst_cnt != exp && g < budget) begin
      step();
      g++;
    end
    chk(tag, burst_cnt, exp);
  endtask

  initial begin
    int base, r0, e0;
    rst = 1'b1; fifo_clr = 1'b1; m_ready = 1'b1; wr_en = 1'b0; wr_data = 8'h00; w_en = 1'b0;
    step(); step();
    rst = 1'b0; fifo_clr = 1'b0;
    chk("rst_ren", ren, 1'b0);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_last", m_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bcnt", burst_cnt, 8'd0);

    // threshold burst
    base = log_q.size();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h11 + 8'(i); step();
    end
    wr_en = 1'b0;
    chk("thr_idle_ren", ren, 1'b0);
    chk("thr_idle_busy", busy, 1'b0);
    step();
    chk("thr_ren1", ren, 1'b1); chk("thr_busy", busy, 1'b1); chk("thr_valid0", m_valid, 1'b0);
    step();
    chk("thr_ren2", ren, 1'b1); chk("thr_d0", m_data, 8'h11); chk("thr_l0", m_last, 1'b0);
    step();
    chk("thr_ren3", ren, 1'b1); chk("thr_d1", m_data, 8'h12);
    step();
    chk("thr_ren4", ren, 1'b1); chk("thr_d2", m_data, 8'h13); chk("thr_l2", m_last, 1'b0);
    step();
    chk("thr_ren5", ren, 1'b0); chk("thr_d3", m_data, 8'h14); chk("thr_l3", m_last, 1'b1);
    step();
    chk("thr_valid_end", m_valid, 1'b0); chk("thr_busy_end", busy, 1'b0);
    chk("thr_bcnt", burst_cnt, 8'd1);
    chk("thr_beats", log_q.size() - base, 4);

    // timeout partial burst
    wr_en = 1'b1; wr_data = 8'hA1; step();
    wr_data = 8'hA2; step();
    wr_en = 1'b0;
    for (int k = 2; k < 8; k++) begin
      chk($sformatf("to_noren_%0d", k), ren, 1'b0);
      step();
    end
    chk("to_start_busy", busy, 1'b0);
    step();
    chk("to_ren", ren, 1'b1); chk("to_busy", busy, 1'b1);
    step();
    chk("to_d0", m_data, 8'hA1); chk("to_l0", m_last, 1'b0); chk("to_ren2", ren, 1'b1);
    step();
    chk("to_d1", m_data, 8'hA2); chk("to_l1", m_last, 1'b1); chk("to_ren3", ren, 1'b0);
    step();
    chk("to_bcnt", burst_cnt, 8'd2); chk("to_fifo_empty", fcnt, 5'd0);

    // backpressure
    m_ready = 1'b0;
    r0 = ren_pulses;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'h31 + 8'(i); step();
    end
    wr_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("bp_hold_%0d", k), {ren, m_valid, m_data}, {1'b0, 1'b1, 8'h31});
    end
    chk("bp_ren_pulses", ren_pulses - r0, 2);
    base = log_q.size();
    m_ready = 1'b1;
    wait_bc(8'd3, 30, "bp_bcnt3");
    wait_bc(8'd4, 40, "bp_bcnt4");
    chk("bp_beats", log_q.size() - base, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("bp_beat_%0d", i), log_q[base + i], {(i == 3 || i == 5) ? 1'b1 : 1'b0, 8'h31 + 8'(i)});

    // full FIFO preloaded while the drain is held in reset
    rst = 1'b1;
    e0 = ren_empty;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'h40 + 8'(i); step();
      if (i == 0) chk("full_ren_in_rst", ren, 1'b0);
    end
    wr_en = 1'b0;
    chk("full_bcnt_rst", burst_cnt, 8'd0);
    rst = 1'b0;
    base = log_q.size();
    wait_bc(8'd4, 100, "full_bcnt");
    chk("full_beats", log_q.size() - base, 16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("full_beat_%0d", i), log_q[base + i], {(i % 4 == 3) ? 1'b1 : 1'b0, 8'h40 + 8'(i)});
    chk("full_ren_empty", ren_empty - e0, 0);
    chk("full_fifo_drained", fcnt, 5'd0);

    // reset mid-burst after the 2nd beat is captured
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h51 + 8'(i); step();
    end
    wr_en = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    chk("mid_ren_forced", ren, 1'b0);
    step();
    rst = 1'b0;
    chk("mid_valid", m_valid, 1'b0); chk("mid_busy", busy, 1'b0);
    chk("mid_bcnt", burst_cnt, 8'd0); chk("mid_ren", ren, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("mid_nolast_%0d", k), m_last, 1'b0);
      step();
    end
    wait_bc(8'd1, 40, "mid_drain_bcnt");
    chk("mid_tail0", log_q[log_q.size() - 2], {1'b0, 8'h53});
    chk("mid_tail1", log_q[log_q.size() - 1], {1'b1, 8'h54});

    // burst_cnt wrap on the single-beat instance
    begin
      int g = 0;
      w_en = 1'b1;
      while (w_accepts < 255 && g < 2000) begin step(); g++; end
      chk("wrap_255", w_burst_cnt, 8'd255);
      g = 0;
      while (w_accepts < 256 && g < 20) begin step(); g++; end
      chk("wrap_0", w_burst_cnt, 8'd0);
      w_en = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
